// File: rtl/raptor64_gshare_bht.sv
// Raptor64 two-level branch predictor: a table of saturating counters indexed
// by fetch pc and a speculative global history register. The index is either
// a concat of pc bits and history, or a gshare XOR. The table is initialised by
// a hardware sweep after reset or clear, and mispredicts are counted.
module raptor64_gshare_bht #(
  parameter int IDX_BITS = 8,
  parameter int GHR_BITS = 3,
  parameter int CTR_BITS = 2,
  parameter int XOR_MODE = 0,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic [63:0]         i_pc,
  input  logic                i_spec_push,
  output logic                o_predict_taken,
  output logic [GHR_BITS-1:0] o_predict_ghr,
  output logic                o_ready,
  input  logic                i_upd_valid,
  input  logic [63:0]         i_upd_pc,
  input  logic [GHR_BITS-1:0] i_upd_ghr,
  input  logic                i_upd_taken,
  input  logic                i_upd_mispredict,
  output logic [CNT_BITS-1:0] o_mispredict_cnt
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [IDX_BITS-1:0] r_sweepIdx;
  logic [GHR_BITS-1:0] r_ghr;
  logic [CNT_BITS-1:0] r_misCnt;
  logic [CTR_BITS-1:0] r_table [DEPTH];

  logic                w_ready;
  logic                w_sweepWe;
  logic                w_runClear;
  logic                w_doUpdate;
  logic                w_doRepair;
  logic [IDX_BITS-1:0] w_rdIdx;
  logic [IDX_BITS-1:0] w_updIdx;
  logic                w_rdMsb;
  logic [CTR_BITS-1:0] w_updCtr;
  logic [CTR_BITS-1:0] w_updNext;
  logic [GHR_BITS-1:0] w_repairGhr;
  logic [GHR_BITS-1:0] w_pushGhr;
  logic                w_unused;

  // Only the low pc bits take part in indexing; the rest are deliberately ignored.
  assign w_unused = ^{i_pc, i_upd_pc, i_upd_ghr};

  // Index formation: gshare folds history into the low pc bits, concat appends it.
  if (XOR_MODE != 0) begin : g_gshare
    assign w_rdIdx  = i_pc[IDX_BITS-1:0]     ^ {{(IDX_BITS-GHR_BITS){1'b0}}, r_ghr};
    assign w_updIdx = i_upd_pc[IDX_BITS-1:0] ^ {{(IDX_BITS-GHR_BITS){1'b0}}, i_upd_ghr};
  end else begin : g_concat
    assign w_rdIdx  = {i_pc[IDX_BITS-GHR_BITS-1:0], r_ghr};
    assign w_updIdx = {i_upd_pc[IDX_BITS-GHR_BITS-1:0], i_upd_ghr};
  end

  // History shift values; a one-bit history simply holds the newest direction.
  if (GHR_BITS == 1) begin : g_ghrOne
    assign w_repairGhr = i_upd_taken;
    assign w_pushGhr   = o_predict_taken;
  end else begin : g_ghrMany
    assign w_repairGhr = {i_upd_ghr[GHR_BITS-2:0], i_upd_taken};
    assign w_pushGhr   = {r_ghr[GHR_BITS-2:0], o_predict_taken};
  end

  // Both table reads are asynchronous, so a same-cycle write is not yet visible.
  assign w_rdMsb  = r_table[w_rdIdx][CTR_BITS-1];
  assign w_updCtr = r_table[w_updIdx];

  // A clear in RUN wins over any update presented in the same cycle.
  assign w_runClear = w_ready & i_clear;
  assign w_doUpdate = w_ready & ~i_clear & i_upd_valid;
  assign w_doRepair = w_doUpdate & i_upd_mispredict;

  assign o_predict_taken  = w_ready & w_rdMsb;
  assign o_predict_ghr    = r_ghr;
  assign o_ready          = w_ready;
  assign o_mispredict_cnt = r_misCnt;

  // State register: reset always restarts the init sweep.
  always_ff @(posedge clk) begin
    if (rst) r_state <= SWEEP;
    else     r_state <= w_nextState;
  end

  // Next state: the sweep finishes after writing the last entry; clear re-enters it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      SWEEP: if (!i_clear && (&r_sweepIdx)) w_nextState = RUN;
      RUN:   if (i_clear)                   w_nextState = SWEEP;
      default: w_nextState = SWEEP;
    endcase
  end

  // State outputs: sweep writes the table, run exposes the predictor as ready.
  always_comb begin
    w_ready   = 1'b0;
    w_sweepWe = 1'b0;
    case (r_state)
      SWEEP:   w_sweepWe = 1'b1;
      RUN:     w_ready   = 1'b1;
      default: w_sweepWe = 1'b1;
    endcase
  end

  // Sweep pointer walks every entry once, restarting at zero on reset or clear.
  always_ff @(posedge clk) begin
    if (rst || i_clear)  r_sweepIdx <= '0;
    else if (w_sweepWe)  r_sweepIdx <= r_sweepIdx + IDX_BITS'(1);
  end

  // Saturating counter step for the resolved branch direction.
  always_comb begin
    w_updNext = w_updCtr;
    if (i_upd_taken && (w_updCtr != CTR_MAX))
      w_updNext = w_updCtr + CTR_BITS'(1);
    else if (!i_upd_taken && (w_updCtr != '0))
      w_updNext = w_updCtr - CTR_BITS'(1);
  end

  // Single table write port shared by the init sweep and EX-stage updates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_sweepWe)       r_table[r_sweepIdx] <= CTR_INIT;
      else if (w_doUpdate) r_table[w_updIdx]   <= w_updNext;
    end
  end

  // Global history: mispredict repair takes priority over a speculative push.
  always_ff @(posedge clk) begin
    if (rst || w_runClear)       r_ghr <= '0;
    else if (w_doRepair)         r_ghr <= w_repairGhr;
    else if (w_ready && i_spec_push) r_ghr <= w_pushGhr;
  end

  // Mispredict counter saturates at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || w_runClear)              r_misCnt <= '0;
    else if (w_doRepair && !(&r_misCnt)) r_misCnt <= r_misCnt + CNT_BITS'(1);
  end

endmodule

// File: tb/tb_raptor64_gshare_bht.sv
// Bench for raptor64_gshare_bht: a concat-index instance and a gshare instance
// with a 4-bit mispredict counter share one stimulus stream and are compared
// every cycle against a behavioural model, plus directed scenario checks.
module tb_raptor64_gshare_bht;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [63:0] pc = '0;
  logic        specPush = 1'b0;
  logic        updValid = 1'b0;
  logic [63:0] updPc = '0;
  logic [2:0]  updGhr = '0;
  logic        updTaken = 1'b0;
  logic        updMispredict = 1'b0;

  logic        predA, predB, readyA, readyB;
  logic [2:0]  ghrA, ghrB;
  logic [15:0] cntA;
  logic [3:0]  cntB;

  int checks = 0;
  int errors = 0;

  // Model state (index 0 = concat instance, index 1 = gshare instance)
  int tbl [2][256];
  int ghrM [2] = '{0, 0};
  int cntM [2] = '{0, 0};
  int cntMax [2] = '{65535, 15};
  int remaining = 256;
  int predExp [2];

  // Values observed at the last sampling point
  int obsPredA, obsPredB, obsGhrA, obsGhrB, obsCntA, obsCntB, obsReadyA;

  raptor64_gshare_bht #(.IDX_BITS(8), .GHR_BITS(3), .CTR_BITS(2), .XOR_MODE(0), .CNT_BITS(16)) dutA (
    .clk(clk), .rst(rst), .i_clear(clear), .i_pc(pc), .i_spec_push(specPush),
    .o_predict_taken(predA), .o_predict_ghr(ghrA), .o_ready(readyA),
    .i_upd_valid(updValid), .i_upd_pc(updPc), .i_upd_ghr(updGhr),
    .i_upd_taken(updTaken), .i_upd_mispredict(updMispredict), .o_mispredict_cnt(cntA)
  );

  raptor64_gshare_bht #(.IDX_BITS(8), .GHR_BITS(3), .CTR_BITS(2), .XOR_MODE(1), .CNT_BITS(4)) dutB (
    .clk(clk), .rst(rst), .i_clear(clear), .i_pc(pc), .i_spec_push(specPush),
    .o_predict_taken(predB), .o_predict_ghr(ghrB), .o_ready(readyB),
    .i_upd_valid(updValid), .i_upd_pc(updPc), .i_upd_ghr(updGhr),
    .i_upd_taken(updTaken), .i_upd_mispredict(updMispredict), .o_mispredict_cnt(cntB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int idxOf(input int k, input logic [63:0] p, input int g);
    if (k == 1) return int'(p[7:0]) ^ g;
    return int'(p[4:0]) * 8 + g;
  endfunction

  task automatic startSweep();
    remaining = 256;
    for (int k = 0; k < 2; k++) begin
      ghrM[k] = 0;
      cntM[k] = 0;
      for (int i = 0; i < 256; i++) tbl[k][i] = 1;
    end
  endtask

  task automatic modelUpdate();
    int i;
    if (rst) startSweep();
    else if (remaining > 0) remaining = clear ? 256 : remaining - 1;
    else if (clear) startSweep();
    else begin
      for (int k = 0; k < 2; k++) begin
        if (updValid) begin
          i = idxOf(k, updPc, int'(updGhr));
          if (updTaken) tbl[k][i] = (tbl[k][i] < 3) ? tbl[k][i] + 1 : 3;
          else          tbl[k][i] = (tbl[k][i] > 0) ? tbl[k][i] - 1 : 0;
          if (updMispredict) begin
            ghrM[k] = ((int'(updGhr) * 2) + int'(updTaken)) % 8;
            cntM[k] = (cntM[k] < cntMax[k]) ? cntM[k] + 1 : cntMax[k];
          end
        end
        if (specPush && !(updValid && updMispredict))
          ghrM[k] = (ghrM[k] * 2 + predExp[k]) % 8;
      end
    end
  endtask

  // Drive one cycle of inputs, compare all outputs at the falling edge, then advance.
  task automatic applyStimulus(input bit r, input bit c, input logic [63:0] p, input bit sp,
                               input bit uv, input logic [63:0] up, input logic [2:0] ug,
                               input bit ut, input bit um);
    bit readyExp;
    rst = r; clear = c; pc = p; specPush = sp;
    updValid = uv; updPc = up; updGhr = ug; updTaken = ut; updMispredict = um;
    @(negedge clk);
    readyExp = (remaining == 0);
    for (int k = 0; k < 2; k++)
      predExp[k] = (readyExp && tbl[k][idxOf(k, pc, ghrM[k])] >= 2) ? 1 : 0;
    obsPredA = int'(predA); obsPredB = int'(predB);
    obsGhrA = int'(ghrA);   obsGhrB = int'(ghrB);
    obsCntA = int'(cntA);   obsCntB = int'(cntB);
    obsReadyA = int'(readyA);
    checkOutput("readyA", readyA, readyExp);
    checkOutput("readyB", readyB, readyExp);
    checkOutput("predA", predA, predExp[0]);
    checkOutput("predB", predB, predExp[1]);
    checkOutput("ghrA", ghrA, ghrM[0]);
    checkOutput("ghrB", ghrB, ghrM[1]);
    checkOutput("cntA", cntA, cntM[0]);
    checkOutput("cntB", cntB, cntM[1]);
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic idle(input logic [63:0] p);
    applyStimulus(0, 0, p, 0, 0, 64'h0, 3'b000, 0, 0);
  endtask

  // Count cycles with ready low until it rises, bounded so a stuck sweep still ends.
  task automatic countSweep(input string tag);
    int n = 0;
    do begin
      idle(64'h0);
      if (obsReadyA == 0) n++;
    end while (obsReadyA == 0 && n < 1000);
    checkOutput(tag, n, 256);
  endtask

  int satUp [5]   = '{0, 1, 1, 1, 1};
  int satDown [5] = '{1, 1, 0, 0, 0};

  initial begin
    startSweep();
    @(posedge clk); #1;

    // Init sweep, then a reset in the middle of a sweep
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    countSweep("sweepLen");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) idle(64'h0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    countSweep("sweepRestartLen");

    // Counter saturation up then down at pc 0x14
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 64'h14, 0, 1, 64'h14, 3'b000, 1, 0);
      checkOutput("satUpPred", obsPredA, satUp[i]);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 64'h14, 0, 1, 64'h14, 3'b000, 0, 0);
      checkOutput("satDownPred", obsPredA, satDown[i]);
    end
    idle(64'h14);
    checkOutput("satFloorPred", obsPredA, 0);

    // Train taken paths, speculate three times, then repair over a push
    for (int g = 0; g < 3; g++) begin
      applyStimulus(0, 0, 0, 0, 1, 64'h30, (g == 0) ? 3'd0 : (g == 1) ? 3'd1 : 3'd3, 1, 0);
      applyStimulus(0, 0, 0, 0, 1, 64'h30, (g == 0) ? 3'd0 : (g == 1) ? 3'd1 : 3'd3, 1, 0);
    end
    applyStimulus(0, 0, 64'h30, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 64'h30, 1, 0, 0, 0, 0, 0);
    checkOutput("specGhr1", obsGhrA, 1);
    applyStimulus(0, 0, 64'h30, 1, 0, 0, 0, 0, 0);
    checkOutput("specGhr3", obsGhrA, 3);
    applyStimulus(0, 0, 64'h30, 1, 1, 64'h55, 3'b010, 0, 1);
    checkOutput("specGhr7", obsGhrA, 7);
    idle(64'h0);
    checkOutput("repairGhr", obsGhrA, 4);
    checkOutput("repairCnt", obsCntA, 1);

    // Clear mid-run with a mispredicting update that must be dropped
    applyStimulus(0, 1, 64'h20, 0, 1, 64'h20, 3'b000, 1, 1);
    countSweep("clearSweepLen");
    idle(64'h20);
    checkOutput("clearGhr", obsGhrA, 0);
    checkOutput("clearCntA", obsCntA, 0);
    checkOutput("clearCntB", obsCntB, 0);
    checkOutput("clearPred", obsPredA, 0);

    // Gshare aliasing: pc 0x0F with history 5 lands on entry 0x0A
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 64'h0F, 3'b101, 1, 0);
    idle(64'h0A);
    checkOutput("gsharePredAlias", obsPredB, 1);
    idle(64'h0F);
    checkOutput("gsharePredOrig", obsPredB, 0);

    // Same-index write and read in one cycle shows the old counter
    applyStimulus(0, 0, 64'h14, 0, 1, 64'h14, 3'b000, 1, 0);
    checkOutput("collisionOld", obsPredA, 0);
    idle(64'h14);
    checkOutput("collisionNew", obsPredA, 1);

    // Twenty mispredicts saturate the 4-bit counter but not the 16-bit one
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 0, {$urandom, $urandom}, 0, 1, {$urandom, $urandom},
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1);
    idle(64'h0);
    checkOutput("misCntSatB", obsCntB, 15);
    checkOutput("misCntA", obsCntA, 20);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 999) == 0, $urandom_range(0, 299) == 0,
                    {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), {$urandom, $urandom},
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/raptor64_gshare_bht.md
Name: raptor64_gshare_bht

Overview:
Parametrised two-level branch predictor that generalises the Raptor64 branch history table. It adds configurable table depth, history length and counter width, plus a selectable concat or gshare (XOR) index. It keeps a speculative global history register with mispredict repair, clears its table with a hardware sweep FSM, and counts mispredicts. It sits between IF (prediction lookup) and EX (resolution/update) of the Raptor64 pipeline.

Parameters:
IDX_BITS, 8, table index width; DEPTH = 2**IDX_BITS entries.
GHR_BITS, 3, global history length; legal range 1..IDX_BITS-1.
CTR_BITS, 2, saturating counter width; legal range 2..4.
XOR_MODE, 0, 0 = concat index {pc[IDX_BITS-GHR_BITS-1:0], ghr}; 1 = gshare index pc[IDX_BITS-1:0] ^ zero-extended ghr.
CNT_BITS, 16, mispredict counter width.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
clear  in  1  pulse; starts a table re-init sweep
pc  in  64  IF-stage fetch address
spec_push  in  1  IF has predicted a branch; shift predicted direction into ghr
predict_taken  out  1  prediction for pc
predict_ghr  out  GHR_BITS  ghr snapshot used for this lookup; carried down the pipe
ready  out  1  table valid; sweep not active
upd_valid  in  1  EX has resolved a branch (advanceX & isBranch, qualified upstream)
upd_pc  in  64  EX-stage branch address
upd_ghr  in  GHR_BITS  snapshot that travelled with the branch
upd_taken  in  1  resolved direction
upd_mispredict  in  1  resolved direction differs from prediction
mispredict_cnt  out  CNT_BITS  saturating mispredict count

Behaviour:
- Counters: CTR_BITS unsigned, saturating at 0 and 2**CTR_BITS-1. Taken increments; not-taken decrements. Predict taken when counter MSB is 1. Init value is 2**(CTR_BITS-1)-1 (weakly not-taken; 1 for the default configuration).
- Read index uses pc and the current ghr. Update index uses upd_pc and upd_ghr. Both use the same XOR_MODE formula.
- Table read is asynchronous. predict_taken is combinational from pc and ghr, and is forced to 0 while ready=0.
- Writes occur at posedge. A read in the same cycle as a write to the same index returns the pre-write value. Back-to-back updates to the same index accumulate correctly.
- FSM has two states: SWEEP and RUN.
  - rst (in any state, including mid-sweep) sets state=SWEEP, sweep_idx=0, ghr=0, mispredict_cnt=0 and ready=0.
  - In SWEEP, each clock writes the init value to table[sweep_idx] and increments sweep_idx. After the write of index DEPTH-1, the FSM moves to RUN and ready=1 on the next cycle. A sweep takes exactly DEPTH clocks.
  - In RUN, a clear pulse enters SWEEP with sweep_idx=0, ghr=0 and mispredict_cnt=0. The update presented in that same cycle is dropped.
  - In SWEEP, clear restarts the sweep at index 0.
  - In SWEEP, upd_valid and spec_push are ignored; no table write, ghr held, counter held.
- In RUN, when upd_valid=1:
  - table[upd_idx] gets its saturated next value.
  - If upd_mispredict=1: ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken}, and mispredict_cnt increments, saturating at all-ones. (For GHR_BITS=1, ghr <= upd_taken.)
- In RUN, when spec_push=1 and no mispredict repair is occurring: ghr <= {ghr[GHR_BITS-2:0], predict_taken}.
- Simultaneous spec_push and mispredict repair: the repair wins and the push is discarded.
- predict_ghr always equals the current ghr register.
- Reset values: predict_taken=0, predict_ghr=0, ready=0, mispredict_cnt=0.

Test Plan:
1. Init sweep: rst high 2 cycles, then low.
   - ready=0 for exactly 256 clocks, then ready=1.
   - Every entry reads counter 1, so predict_taken=0 for all pc[7:0].
   - Pulse rst at sweep_idx=100: sweep restarts and takes 256 more clocks.
2. Saturation: upd_valid with upd_pc=0x14, upd_ghr=0 and upd_taken=1, repeated 5 times.
   - The counter goes 1,2,3,3,3.
   - predict_taken=1 for pc=0x14 with ghr=0 once the counter reaches 2.
   - 5 not-taken updates then take it 3,2,1,0,0, and predict_taken=0.
3. Speculation and repair: spec_push for 3 cycles with predict_taken=1 gives ghr 1,3,7. Then upd_valid, upd_mispredict=1, upd_ghr=3'b010, upd_taken=0 in the same cycle as spec_push=1.
   - ghr=3'b100.
   - mispredict_cnt=1.
4. XOR_MODE=1, GHR_BITS=3: update pc=0x0F with ghr=3'b101 three times taken.
   - Entry 0x0A reaches 3, and pc=0x0A with ghr=0 predicts taken.
   - pc=0x0F with ghr=0 still predicts not-taken.
5. Clear mid-run with upd_valid=1 on pc=0x20:
   - The update is dropped.
   - ready=0 for 256 clocks.
   - ghr=0 and mispredict_cnt=0.
   - Entry 0x20 reads 1 afterwards.
6. Counter saturation: CNT_BITS=4 with 20 mispredicts.
   - mispredict_cnt holds at 15.
   - Same-index write/read collision returns the old counter value on predict_taken that cycle.
